// File: rtl/uart_rx_cfg_if.sv
// ----------------------------------------------------------------------------
// uart_rx_cfg_if
// Receive-side output bundle of uart_rx_cfg.
//   tx_o          [DATA_LENGTH] last received word, LSB = first bit on line
//   tx_o_v        one-cycle strobe, tx_o and error flags valid
//   err_frame_o   stop bit sampled low (qualified by tx_o_v)
//   err_parity_o  parity mismatch (qualified by tx_o_v)
//   busy_o        receiver not idle
//   break_o       one-cycle break strobe (only with UART_RX_BREAK_EN)
// Modports: master = receiver (drives), slave = byte-stream consumer.
// Optional macro: UART_RX_BREAK_EN adds break_o.
// ----------------------------------------------------------------------------
interface uart_rx_cfg_if #(
    parameter int DATA_LENGTH = 8
);
    logic [DATA_LENGTH-1:0] tx_o;
    logic                   tx_o_v;
    logic                   err_frame_o;
    logic                   err_parity_o;
    logic                   busy_o;
`ifdef UART_RX_BREAK_EN
    logic                   break_o;
`endif

    modport master (
        output tx_o,
        output tx_o_v,
        output err_frame_o,
        output err_parity_o,
`ifdef UART_RX_BREAK_EN
        output break_o,
`endif
        output busy_o
    );

    modport slave (
        input tx_o,
        input tx_o_v,
        input err_frame_o,
        input err_parity_o,
`ifdef UART_RX_BREAK_EN
        input break_o,
`endif
        input busy_o
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// ----------------------------------------------------------------------------
// uart_rx_cfg
// Parametrised oversampling UART receiver with majority-vote bit sampling,
// false-start rejection, optional parity, 1 or 2 stop bits, framing/parity
// error reporting and a receive enable that gates only new start bits.
//
// Ports:
//   clk_i    system clock
//   rst_n_i  synchronous active-low reset
//   rx_i     asynchronous serial line, idle high
//   en_i     receive enable (gates start-bit detection only)
//   rx_out   uart_rx_cfg_if.master: tx_o, tx_o_v, err_frame_o,
//            err_parity_o, busy_o (and break_o with UART_RX_BREAK_EN)
//
// Optional macro: UART_RX_BREAK_EN
//   Defined  : an all-zero frame (data, parity, stop) pulses break_o instead
//              of tx_o_v and the receiver waits in BRK_WAIT for the line to
//              return high.
//   Undefined: the same line condition is delivered as tx_o=0, tx_o_v=1,
//              err_frame_o=1.
// ----------------------------------------------------------------------------
module uart_rx_cfg #(
    parameter int DATA_LENGTH = 8,
    parameter int SAMPLE_RATE = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          rx_i,
    input  logic          en_i,
    uart_rx_cfg_if.master rx_out
);

    localparam int M  = SAMPLE_RATE / 2;
    localparam int CW = $clog2(SAMPLE_RATE);

    localparam logic [CW-1:0] C_VOTE0     = CW'(M - 1);
    localparam logic [CW-1:0] C_VOTE1     = CW'(M);
    localparam logic [CW-1:0] C_VOTE2     = CW'(M + 1);
    localparam logic [CW-1:0] C_DEC       = CW'(M + 2);
    localparam logic [CW-1:0] C_END       = CW'(SAMPLE_RATE - 1);
    localparam logic [3:0]    C_LAST_DATA = 4'(DATA_LENGTH - 1);
    localparam logic [3:0]    C_LAST_STOP = 4'(STOP_BITS - 1);
    localparam bit            HAS_PAR     = (PARITY_MODE != 0);

`ifdef UART_RX_BREAK_EN
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP     = 3'd4,
        S_BRK_WAIT = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP     = 3'd4
    } state_t;
`endif

    state_t r_state;
    state_t w_next;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_s_d;
    logic [CW-1:0]          r_ctr_sample;
    logic [3:0]             r_ctr_bit;
    logic                   r_v0;
    logic                   r_v1;
    logic                   r_v2;
    logic [DATA_LENGTH-1:0] r_shift;
    logic                   r_par_acc;
    logic                   r_err_par;
    logic                   r_err_frm;
    logic [DATA_LENGTH-1:0] r_tx;
    logic                   r_tx_v;
    logic                   r_ef;
    logic                   r_ep;
    logic                   r_busy;

    logic w_rx_s;
    logic w_start_edge;
    logic w_dec;
    logic w_end;
    logic w_vote;
    logic w_last_data;
    logic w_last_stop;
    logic w_par_mis;
    logic w_strobe;

`ifdef UART_RX_BREAK_EN
    logic r_par_bit;
    logic r_stop_hi;
    logic r_brk;
    logic w_break;
    logic w_brk_pulse;
`endif

    // 2-of-3 majority of the mid-bit samples
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign w_rx_s       = r_sync[SYNC_STAGES-1];
    assign w_start_edge = r_rx_s_d & ~w_rx_s & en_i;
    assign w_dec        = (r_ctr_sample == C_DEC);
    assign w_end        = (r_ctr_sample == C_END);
    assign w_vote       = maj3(r_v0, r_v1, r_v2);
    assign w_last_data  = (r_ctr_bit == C_LAST_DATA);
    assign w_last_stop  = (r_ctr_bit == C_LAST_STOP);
    // odd mode flags a mismatch when data^parity is 0, even mode when it is 1
    assign w_par_mis    = (PARITY_MODE == 1) ? ~(r_par_acc ^ w_vote) : (r_par_acc ^ w_vote);

`ifdef UART_RX_BREAK_EN
    assign w_break = (r_shift == '0) & (HAS_PAR ? ~r_par_bit : 1'b1) & ~r_stop_hi & ~w_vote;
`endif

    // input synchroniser and one-cycle delayed copy for falling-edge detect
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_sync   <= '1;
            r_rx_s_d <= 1'b1;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], rx_i};
            r_rx_s_d <= w_rx_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state and end-of-frame strobe decisions
    always_comb begin
        w_next   = r_state;
        w_strobe = 1'b0;
`ifdef UART_RX_BREAK_EN
        w_brk_pulse = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_next = S_START;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_START: begin
                if (w_dec && w_vote) begin
                    w_next = S_IDLE;            // false start
                end else if (w_end) begin
                    w_next = S_DATA;
                end else begin
                    w_next = S_START;
                end
            end
            S_DATA: begin
                if (w_end && w_last_data) begin
                    if (HAS_PAR) begin
                        w_next = S_PARITY;
                    end else begin
                        w_next = S_STOP;
                    end
                end else begin
                    w_next = S_DATA;
                end
            end
            S_PARITY: begin
                if (w_end) begin
                    w_next = S_STOP;
                end else begin
                    w_next = S_PARITY;
                end
            end
            S_STOP: begin
                // finishing at mid-bit of the last stop lets the next start edge resync
                if (w_dec && w_last_stop) begin
`ifdef UART_RX_BREAK_EN
                    if (w_break) begin
                        w_next      = S_BRK_WAIT;
                        w_brk_pulse = 1'b1;
                    end else begin
                        w_next   = S_IDLE;
                        w_strobe = 1'b1;
                    end
`else
                    w_next   = S_IDLE;
                    w_strobe = 1'b1;
`endif
                end else begin
                    w_next = S_STOP;
                end
            end
`ifdef UART_RX_BREAK_EN
            S_BRK_WAIT: begin
                if (w_rx_s) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_BRK_WAIT;
                end
            end
`endif
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // oversample and bit counters; both parked at 0 while idle
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_ctr_sample <= '0;
            r_ctr_bit    <= 4'd0;
        end else if (r_state == S_IDLE || w_next == S_IDLE) begin
            r_ctr_sample <= '0;
            r_ctr_bit    <= 4'd0;
        end else begin
            if (w_end) begin
                r_ctr_sample <= '0;
            end else begin
                r_ctr_sample <= r_ctr_sample + {{(CW-1){1'b0}}, 1'b1};
            end
            if (w_end && (r_state == S_DATA || r_state == S_STOP)) begin
                if (r_state == S_DATA && w_last_data) begin
                    r_ctr_bit <= 4'd0;
                end else begin
                    r_ctr_bit <= r_ctr_bit + 4'd1;
                end
            end
        end
    end

    // capture the three samples around mid-bit
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_v0 <= 1'b1;
            r_v1 <= 1'b1;
            r_v2 <= 1'b1;
        end else begin
            if (r_ctr_sample == C_VOTE0) r_v0 <= w_rx_s;
            if (r_ctr_sample == C_VOTE1) r_v1 <= w_rx_s;
            if (r_ctr_sample == C_VOTE2) r_v2 <= w_rx_s;
        end
    end

    // frame datapath: shift register, parity accumulator, error tracking
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_shift   <= '0;
            r_par_acc <= 1'b0;
            r_err_par <= 1'b0;
            r_err_frm <= 1'b0;
`ifdef UART_RX_BREAK_EN
            r_par_bit <= 1'b0;
            r_stop_hi <= 1'b0;
`endif
        end else if (r_state == S_IDLE) begin
            r_par_acc <= 1'b0;
            r_err_par <= 1'b0;
            r_err_frm <= 1'b0;
`ifdef UART_RX_BREAK_EN
            r_par_bit <= 1'b0;
            r_stop_hi <= 1'b0;
`endif
        end else if (w_dec) begin
            if (r_state == S_DATA) begin
                r_shift   <= {w_vote, r_shift[DATA_LENGTH-1:1]};
                r_par_acc <= r_par_acc ^ w_vote;
            end
            if (r_state == S_PARITY) begin
                r_err_par <= w_par_mis;
`ifdef UART_RX_BREAK_EN
                r_par_bit <= w_vote;
`endif
            end
            if (r_state == S_STOP) begin
                if (!w_vote) r_err_frm <= 1'b1;
`ifdef UART_RX_BREAK_EN
                if (w_vote) r_stop_hi <= 1'b1;
`endif
            end
        end
    end

    // registered outputs; error flags only ever high alongside the strobe
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_tx   <= '0;
            r_tx_v <= 1'b0;
            r_ef   <= 1'b0;
            r_ep   <= 1'b0;
            r_busy <= 1'b0;
`ifdef UART_RX_BREAK_EN
            r_brk  <= 1'b0;
`endif
        end else begin
            r_tx_v <= w_strobe;
            if (w_strobe) r_tx <= r_shift;
            // the final stop vote is folded in here since it is decided this cycle
            r_ef   <= w_strobe & (r_err_frm | ~w_vote);
            r_ep   <= w_strobe & r_err_par;
            r_busy <= (w_next != S_IDLE);
`ifdef UART_RX_BREAK_EN
            r_brk  <= w_brk_pulse;
`endif
        end
    end

    assign rx_out.tx_o         = r_tx;
    assign rx_out.tx_o_v       = r_tx_v;
    assign rx_out.err_frame_o  = r_ef;
    assign rx_out.err_parity_o = r_ep;
    assign rx_out.busy_o       = r_busy;
`ifdef UART_RX_BREAK_EN
    assign rx_out.break_o      = r_brk;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
module tb_uart_rx_cfg;

    localparam int SR  = 16;
    localparam int L_A = 2 + 9 * SR + SR / 2 + 3;    // 8N1, 2 sync stages
    localparam int L_B = 3 + 11 * SR + SR / 2 + 3;   // 8E2, 3 sync stages

    typedef struct {
        logic [7:0] d;
        logic       ef;
        logic       ep;
        logic       busy;
        int         cyc;
    } rec_t;

    logic clk;
    logic rst_n;
    logic rx_a;
    logic rx_b;
    logic en;
    int   cyc;
    int   checks;
    int   failures;
    int   leak_a;
    int   leak_b;
    int   brk_a;
    rec_t q_a[$];
    rec_t q_b[$];
    rec_t mon_r;

    uart_rx_cfg_if #(.DATA_LENGTH(8)) if_a ();
    uart_rx_cfg_if #(.DATA_LENGTH(8)) if_b ();

    uart_rx_cfg #(.DATA_LENGTH(8), .SAMPLE_RATE(SR), .PARITY_MODE(0), .STOP_BITS(1), .SYNC_STAGES(2))
        dut_a (.clk_i(clk), .rst_n_i(rst_n), .rx_i(rx_a), .en_i(en), .rx_out(if_a.master));

    uart_rx_cfg #(.DATA_LENGTH(8), .SAMPLE_RATE(SR), .PARITY_MODE(2), .STOP_BITS(2), .SYNC_STAGES(3))
        dut_b (.clk_i(clk), .rst_n_i(rst_n), .rx_i(rx_b), .en_i(en), .rx_out(if_b.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // record every delivered word and any flag raised without a strobe
    always @(negedge clk) begin
        if (if_a.tx_o_v) begin
            mon_r = '{if_a.tx_o, if_a.err_frame_o, if_a.err_parity_o, if_a.busy_o, cyc};
            q_a.push_back(mon_r);
        end else if (if_a.err_frame_o || if_a.err_parity_o) begin
            leak_a = leak_a + 1;
        end
        if (if_b.tx_o_v) begin
            mon_r = '{if_b.tx_o, if_b.err_frame_o, if_b.err_parity_o, if_b.busy_o, cyc};
            q_b.push_back(mon_r);
        end else if (if_b.err_frame_o || if_b.err_parity_o) begin
            leak_b = leak_b + 1;
        end
`ifdef UART_RX_BREAK_EN
        if (if_a.break_o) brk_a = brk_a + 1;
`endif
    end

    task automatic set_line(input int ln, input logic b);
        if (ln == 0) rx_a = b;
        else         rx_b = b;
    endtask

    // line 0: start, 8 data, stop s0; line 1: start, 8 data, parity p, stops s0 s1
    task automatic send_frame(input int ln, input logic [7:0] d, input logic p,
                              input logic s0, input logic s1, output int t0);
        logic fb[12];
        int   nb;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[1+i] = d[i];
        if (ln == 0) begin
            fb[9] = s0; nb = 10;
        end else begin
            fb[9] = p; fb[10] = s0; fb[11] = s1; nb = 12;
        end
        t0 = cyc;
        for (int i = 0; i < nb; i++) begin
            set_line(ln, fb[i]);
            repeat (SR) @(negedge clk);
        end
    endtask

    task automatic idle(input int ln, input int n);
        set_line(ln, 1'b1);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({if_a.tx_o, if_a.tx_o_v, if_a.err_frame_o, if_a.err_parity_o, if_a.busy_o} !== 12'h000) begin
            failures++;
            $display("FAIL reset_a: outputs %0h required 0", {if_a.tx_o, if_a.tx_o_v, if_a.err_frame_o, if_a.err_parity_o, if_a.busy_o});
        end
        checks++;
        if ({if_b.tx_o, if_b.tx_o_v, if_b.err_frame_o, if_b.err_parity_o, if_b.busy_o} !== 12'h000) begin
            failures++;
            $display("FAIL reset_b: outputs %0h required 0", {if_b.tx_o, if_b.tx_o_v, if_b.err_frame_o, if_b.err_parity_o, if_b.busy_o});
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic_a;
        int   t0;
        rec_t r;
        fork
            send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, t0);
            begin
                repeat (80) @(negedge clk);
                checks++;
                if (if_a.busy_o !== 1'b1) begin
                    failures++;
                    $display("FAIL basic_busy_mid: busy %0b required 1", if_a.busy_o);
                end
            end
        join
        idle(0, 4);
        checks++;
        if (q_a.size() != 1) begin
            failures++;
            $display("FAIL basic_count: strobes %0d required 1", q_a.size());
        end else begin
            r = q_a.pop_front();
            checks++;
            if ({r.d, r.ef, r.ep, r.busy} !== {8'hA5, 3'b000}) begin
                failures++;
                $display("FAIL basic_word: got d=%0h ef=%0b ep=%0b busy=%0b required A5 0 0 0", r.d, r.ef, r.ep, r.busy);
            end
            checks++;
            if (r.cyc < t0 + 1 + L_A - 1 || r.cyc > t0 + 1 + L_A + 1) begin
                failures++;
                $display("FAIL basic_latency: strobe at %0d required %0d", r.cyc, t0 + 1 + L_A);
            end
        end
        q_a.delete();
    endtask

    task automatic test_parity_b;
        int   t0;
        rec_t r;
        for (int k = 0; k < 2; k++) begin
            send_frame(1, 8'h3C, (k == 0) ? 1'b1 : 1'b0, 1'b1, 1'b1, t0);
            idle(1, 4);
            checks++;
            if (q_b.size() != 1) begin
                failures++;
                $display("FAIL parity_count%0d: strobes %0d required 1", k, q_b.size());
            end else begin
                r = q_b.pop_front();
                checks++;
                if ({r.d, r.ef, r.ep} !== {8'h3C, 1'b0, (k == 0) ? 1'b1 : 1'b0}) begin
                    failures++;
                    $display("FAIL parity_word%0d: got d=%0h ef=%0b ep=%0b required 3C 0 %0d", k, r.d, r.ef, r.ep, (k == 0) ? 1 : 0);
                end
            end
            q_b.delete();
        end
    endtask

    task automatic test_false_start;
        int   t0;
        rec_t r;
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        idle(0, 30);
        checks++;
        if (q_a.size() != 0 || if_a.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL false_start: strobes %0d busy %0b required 0 0", q_a.size(), if_a.busy_o);
        end
        send_frame(0, 8'h55, 1'b0, 1'b1, 1'b1, t0);
        idle(0, 4);
        checks++;
        if (q_a.size() != 1) begin
            failures++;
            $display("FAIL after_false_count: strobes %0d required 1", q_a.size());
        end else begin
            r = q_a.pop_front();
            checks++;
            if ({r.d, r.ef, r.ep} !== {8'h55, 2'b00}) begin
                failures++;
                $display("FAIL after_false_word: got %0h ef=%0b ep=%0b required 55 0 0", r.d, r.ef, r.ep);
            end
        end
        q_a.delete();
    endtask

    task automatic test_frame_err;
        int         t0;
        rec_t       r;
        logic [7:0] dv[2];
        dv[0] = 8'h81;
        dv[1] = 8'h7E;
        for (int k = 0; k < 2; k++) begin
            send_frame(0, dv[k], 1'b0, (k == 0) ? 1'b0 : 1'b1, 1'b1, t0);
            idle(0, SR);
            checks++;
            if (q_a.size() != 1) begin
                failures++;
                $display("FAIL frame_err_count%0d: strobes %0d required 1", k, q_a.size());
            end else begin
                r = q_a.pop_front();
                checks++;
                if ({r.d, r.ef, r.ep} !== {dv[k], (k == 0) ? 1'b1 : 1'b0, 1'b0}) begin
                    failures++;
                    $display("FAIL frame_err_word%0d: got %0h ef=%0b required %0h ef=%0d", k, r.d, r.ef, dv[k], (k == 0) ? 1 : 0);
                end
            end
            q_a.delete();
        end
    endtask

    task automatic test_back_to_back;
        int         t0[2];
        int         tx;
        rec_t       r;
        logic [7:0] dv[2];
        dv[0] = 8'h55;
        dv[1] = 8'hAA;
        send_frame(1, dv[0], ^dv[0], 1'b1, 1'b1, t0[0]);
        send_frame(1, dv[1], ^dv[1], 1'b1, 1'b1, t0[1]);
        idle(1, 4);
        checks++;
        if (q_b.size() != 2) begin
            failures++;
            $display("FAIL b2b_count: strobes %0d required 2", q_b.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                r = q_b.pop_front();
                checks++;
                if ({r.d, r.ef, r.ep} !== {dv[k], 2'b00} || r.cyc < t0[k] + L_B || r.cyc > t0[k] + L_B + 2) begin
                    failures++;
                    $display("FAIL b2b_word%0d: got %0h ef=%0b ep=%0b at %0d required %0h 0 0 at %0d", k, r.d, r.ef, r.ep, r.cyc, dv[k], t0[k] + 1 + L_B);
                end
            end
        end
        q_b.delete();
        // third frame: start plus three data bits, then reset inside DATA bit 3
        rx_b = 1'b0;
        repeat (SR) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_b = 1'b1;
            repeat (SR) @(negedge clk);
        end
        rx_b = 1'b0;
        repeat (SR / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({if_b.tx_o, if_b.tx_o_v, if_b.err_frame_o, if_b.err_parity_o, if_b.busy_o} !== 12'h000) begin
            failures++;
            $display("FAIL midframe_reset: outputs %0h required 0", {if_b.tx_o, if_b.tx_o_v, if_b.err_frame_o, if_b.err_parity_o, if_b.busy_o});
        end
        rst_n = 1'b1;
        idle(1, 12 * SR);
        checks++;
        if (q_b.size() != 0) begin
            failures++;
            $display("FAIL midframe_reset_strobe: strobes %0d required 0", q_b.size());
        end
        send_frame(1, 8'h0F, 1'b0, 1'b1, 1'b1, tx);
        idle(1, 4);
        checks++;
        if (q_b.size() != 1) begin
            failures++;
            $display("FAIL after_reset_count: strobes %0d required 1", q_b.size());
        end else begin
            r = q_b.pop_front();
            checks++;
            if ({r.d, r.ef, r.ep} !== {8'h0F, 2'b00}) begin
                failures++;
                $display("FAIL after_reset_word: got %0h ef=%0b ep=%0b required 0F 0 0", r.d, r.ef, r.ep);
            end
        end
        q_b.delete();
    endtask

    task automatic test_enable;
        int   t0;
        rec_t r;
        en = 1'b0;
        send_frame(0, 8'h12, 1'b0, 1'b1, 1'b1, t0);
        idle(0, 8);
        checks++;
        if (q_a.size() != 0) begin
            failures++;
            $display("FAIL enable_off: strobes %0d required 0", q_a.size());
        end
        q_a.delete();
        en = 1'b1;
        fork
            send_frame(0, 8'h34, 1'b0, 1'b1, 1'b1, t0);
            begin
                repeat (40) @(negedge clk);
                en = 1'b0;
            end
        join
        idle(0, 4);
        en = 1'b1;
        checks++;
        if (q_a.size() != 1) begin
            failures++;
            $display("FAIL enable_midframe_count: strobes %0d required 1", q_a.size());
        end else begin
            r = q_a.pop_front();
            checks++;
            if (r.d !== 8'h34) begin
                failures++;
                $display("FAIL enable_midframe_word: got %0h required 34", r.d);
            end
        end
        q_a.delete();
    endtask

    task automatic test_random;
        int         t0;
        rec_t       r;
        logic [7:0] d;
        logic       p;
        logic       s0;
        logic       s1;
        logic       exp_ef;
        logic       exp_ep;
        for (int k = 0; k < 16; k++) begin
            int ln = (k < 8) ? 0 : 1;
            d  = 8'($urandom);
            s0 = ($urandom_range(3) != 0);
            s1 = ($urandom_range(3) != 0);
            p  = ($urandom_range(1) == 0) ? ^d : ~(^d);
            // even-parity receiver: total ones over data and parity must be even
            exp_ep = (ln == 1) ? (^d ^ p) : 1'b0;
            exp_ef = (ln == 1) ? ~(s0 & s1) : ~s0;
            send_frame(ln, d, p, s0, s1, t0);
            idle(ln, 1 + $urandom_range(19));
            checks++;
            if (((ln == 0) ? q_a.size() : q_b.size()) != 1) begin
                failures++;
                $display("FAIL rand%0d_count: strobes %0d required 1", k, (ln == 0) ? q_a.size() : q_b.size());
            end else begin
                r = (ln == 0) ? q_a.pop_front() : q_b.pop_front();
                checks++;
                if ({r.d, r.ef, r.ep} !== {d, exp_ef, exp_ep}) begin
                    failures++;
                    $display("FAIL rand%0d_word: got %0h ef=%0b ep=%0b required %0h ef=%0b ep=%0b", k, r.d, r.ef, r.ep, d, exp_ef, exp_ep);
                end
                checks++;
                if (r.cyc < t0 + ((ln == 0) ? L_A : L_B) || r.cyc > t0 + ((ln == 0) ? L_A : L_B) + 2) begin
                    failures++;
                    $display("FAIL rand%0d_latency: strobe at %0d required %0d", k, r.cyc, t0 + 1 + ((ln == 0) ? L_A : L_B));
                end
            end
            q_a.delete();
            q_b.delete();
        end
        checks++;
        if (leak_a != 0 || leak_b != 0) begin
            failures++;
            $display("FAIL flag_qualify: unqualified flags a=%0d b=%0d required 0", leak_a, leak_b);
        end
    endtask

    task automatic test_break;
        int   t0;
        rec_t r;
        t0 = cyc;
        rx_a = 1'b0;
        repeat (12 * SR) @(negedge clk);
`ifdef UART_RX_BREAK_EN
        checks++;
        if (brk_a != 1 || q_a.size() != 0 || if_a.busy_o !== 1'b1) begin
            failures++;
            $display("FAIL break_low: pulses %0d strobes %0d busy %0b required 1 0 1", brk_a, q_a.size(), if_a.busy_o);
        end
        idle(0, 10);
        checks++;
        if (if_a.busy_o !== 1'b0 || q_a.size() != 0) begin
            failures++;
            $display("FAIL break_release: busy %0b strobes %0d required 0 0", if_a.busy_o, q_a.size());
        end
`else
        idle(0, 10);
        checks++;
        if (q_a.size() != 1) begin
            failures++;
            $display("FAIL break_count: strobes %0d required 1", q_a.size());
        end else begin
            r = q_a.pop_front();
            checks++;
            if ({r.d, r.ef, r.ep} !== {8'h00, 2'b10} || r.cyc < t0 + L_A || r.cyc > t0 + L_A + 2) begin
                failures++;
                $display("FAIL break_word: got %0h ef=%0b ep=%0b at %0d required 00 1 0 at %0d", r.d, r.ef, r.ep, r.cyc, t0 + 1 + L_A);
            end
        end
`endif
        q_a.delete();
        send_frame(0, 8'h33, 1'b0, 1'b1, 1'b1, t0);
        idle(0, 4);
        checks++;
        if (q_a.size() != 1) begin
            failures++;
            $display("FAIL after_break_count: strobes %0d required 1", q_a.size());
        end else begin
            r = q_a.pop_front();
            checks++;
            if ({r.d, r.ef, r.ep} !== {8'h33, 2'b00}) begin
                failures++;
                $display("FAIL after_break_word: got %0h ef=%0b ep=%0b required 33 0 0", r.d, r.ef, r.ep);
            end
        end
        q_a.delete();
    endtask

    initial begin
        cyc      = 0;
        checks   = 0;
        failures = 0;
        leak_a   = 0;
        leak_b   = 0;
        brk_a    = 0;
        rst_n    = 1'b0;
        rx_a     = 1'b1;
        rx_b     = 1'b1;
        en       = 1'b1;
        test_reset();
        test_basic_a();
        test_parity_b();
        test_false_start();
        test_frame_err();
        test_back_to_back();
        test_enable();
        test_random();
        test_break();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Parametrised UART receiver; next generation of the fixed 8N1 receiver.
- Configurable data length, oversample rate, parity mode and stop-bit count.
- Adds false-start rejection, framing/parity error reporting and a receive enable.
- Sits between the pad-side serial input and the byte-stream consumers; drives a one-cycle valid strobe to downstream logic.

Parameters:
DATA_LENGTH, 8, data bits per frame, legal 5..9
SAMPLE_RATE, 16, clocks per bit period, legal 8..64, even
PARITY_MODE, 0, 0 none, 1 odd, 2 even
STOP_BITS, 1, stop bits per frame, legal 1 or 2
SYNC_STAGES, 2, input synchroniser flops, legal 2..3

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  synchronous active-low reset
rx_i  input  1  asynchronous serial line, idle high
en_i  input  1  receive enable; gates detection of new start bits only
tx_o  output  DATA_LENGTH  last received word, LSB = first bit on line
tx_o_v  output  1  one-cycle strobe: tx_o and error flags valid
err_frame_o  output  1  stop bit sampled low; qualified by tx_o_v
err_parity_o  output  1  parity mismatch; qualified by tx_o_v
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n_i low at clk_i edge): state IDLE; all counters 0; tx_o 0; tx_o_v, err_frame_o, err_parity_o, busy_o 0; synchroniser and edge-detect flops load 1. Reset mid-frame discards the frame without any strobe.
- Synchroniser: rx_i passes through SYNC_STAGES flops, giving rx_s. rx_s_d is rx_s delayed one cycle.
- Sample counter: ctr_sample counts 0..SAMPLE_RATE-1 and wraps. It is held at 0 in IDLE and cleared on the IDLE->START transition.
- Voting: the three samples of rx_s at ctr_sample = M-1, M, M+1 (M = SAMPLE_RATE/2) are registered. Their majority vote is valid at ctr_sample = M+2; this is the decision point D for every bit.
- States: IDLE, START, DATA, PARITY, STOP, plus BRK_WAIT (optional feature only).
- IDLE -> START: on rx_s_d=1 & rx_s=0 & en_i=1. Edges with en_i=0 are ignored.
- START:
  - At D, vote=1 is a false start: go to IDLE with no strobe.
  - Otherwise, at ctr_sample = SAMPLE_RATE-1 go to DATA.
- DATA:
  - At D, the vote shifts into the MSB of the shift register (right shift, LSB-first on the line).
  - ctr_bit increments at each bit end.
  - After DATA_LENGTH bits, at bit end, go to PARITY if PARITY_MODE != 0, else go to STOP.
- PARITY:
  - At D, compute XOR of data bits and the parity vote. Mismatch when that XOR = 0 (odd mode) or 1 (even mode).
  - Go to STOP at bit end.
- STOP:
  - Each stop bit is voted at D; any low vote sets the frame error.
  - At D of the final stop bit, in the same cycle: tx_o loads the shift register, tx_o_v=1, error flags are driven, and the state goes to IDLE. Returning at mid-bit allows resync on the next start edge.
- Output hold: tx_o holds until the next strobe. Error flags are 0 whenever tx_o_v=0. Frames with errors are still delivered.
- Latency: tx_o_v asserts SYNC_STAGES + (1 + DATA_LENGTH + P + STOP_BITS - 1)*SAMPLE_RATE + M + 2 + 1 cycles after the rx_i falling edge, where P=1 if parity is enabled. Benches allow ±1 cycle for edge alignment.
- en_i deasserted mid-frame: the frame completes normally.
- Back-to-back frames: a start edge arriving immediately after IDLE re-entry must be accepted; no dead cycles are required beyond the edge detect.

Optional Feature:
- Macro: UART_RX_BREAK_EN.
- Defined:
  - Adds output break_o (1 bit, reset 0).
  - If all data bits, the parity bit (if present) and all stop votes are 0, the frame is a break: break_o pulses for one cycle in place of tx_o_v. tx_o and the error flags are unchanged.
  - The state then goes to BRK_WAIT and stays there until rx_s=1, then returns to IDLE.
- Undefined:
  - No break_o port and no BRK_WAIT state.
  - The same line condition is delivered as tx_o=0, tx_o_v=1, err_frame_o=1.

Test Plan:
- Defaults (8N1, SAMPLE_RATE 16): send 0xA5 -> exactly one tx_o_v pulse, tx_o=0xA5, both error flags 0, busy_o falls the same cycle.
- PARITY_MODE=2: send 0x3C with parity bit 1 -> tx_o=0x3C, err_parity_o=1; resend with parity 0 -> err_parity_o=0.
- rx_i low for 4 clocks then high -> no tx_o_v, state back in IDLE by cycle D; a following valid 0x55 is received correctly.
- Send 0x81 with stop bit driven low -> tx_o=0x81, err_frame_o=1; next frame 0x7E with a good stop bit -> err_frame_o=0.
- STOP_BITS=2: frames 0x55 then 0xAA with no idle gap -> two strobes, correct data; rst_n_i low at DATA bit 3 of a third frame -> no strobe, all outputs 0, the following frame 0x0F is received.
- UART_RX_BREAK_EN defined: rx_i held low for 12 bit periods -> single break_o pulse, no tx_o_v; no frame until rx_i returns high and a new start edge arrives.
